// File: rtl/sdhci_dat_pkg.sv
// Shared SDHCI data-path types: receive FSM states, CRC16 polynomial, word width.
// No logic, so no latency.
// No flow control; this package holds only types and constants.
package sdhci_dat_pkg;

    localparam int          WordWidth = 32;
    localparam logic [15:0] Crc16Poly = 16'h1021;  // x^16 + x^12 + x^5 + 1

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_DATA,
        ST_CRC,
        ST_END_BIT,
        ST_DONE
    } dat_rx_state_e;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? Crc16Poly : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16, one bit per enabled cycle, MSB first, init 0.
// Latency: crc_o reflects a bit one cycle after enable_i.
// No backpressure; clear_i wins over enable_i.
module sd_crc16
    import sdhci_dat_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_o <= '0;
        end else if (clear_i) begin
            crc_o <= '0;
        end else if (enable_i) begin
            crc_o <= crc16_step(crc_o, bit_i);
        end
    end

endmodule

// File: rtl/dat_rx_deserializer.sv
// SD DAT receiver: start bit, block data into 32-bit words, per-line CRC16, end bit.
// Latency: data_valid_o one cycle after the sample completing a word; done_o one cycle after end bit.
// No backpressure: the consumer must accept every data_valid_o pulse; abort_i drops the block.
module dat_rx_deserializer
    import sdhci_dat_pkg::*;
#(
    parameter int MaxBlockBitSize = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sd_clk_en_i,
    input  logic [3:0]                 dat_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [MaxBlockBitSize-1:0] block_size_i,
    input  logic                       bus_width_is_4_i,
    output logic                       data_valid_o,
    output logic [WordWidth-1:0]       data_o,
    output logic                       done_o,
    output logic                       crc_err_o,
    output logic                       end_bit_err_o
);

    localparam int CntW = MaxBlockBitSize + 3;

    dat_rx_state_e               state_q, state_d;
    logic [MaxBlockBitSize-1:0]  blk_size_q;
    logic                        bw4_q;
    logic [CntW-1:0]             bit_cnt_q;
    logic [CntW-1:0]             last_idx;
    logic [3:0]                  crc_cnt_q;
    logic [7:0]                  byte_q, byte_next;
    logic [1:0]                  lane_q;
    logic [WordWidth-1:0]        word_q, word_next;
    logic                        crc_err_q, end_err_q;

    logic                        start_acc, smp, data_smp, crc_smp, end_smp;
    logic                        start_bit, last_data, byte_done;
    logic [3:0]                  line_mask, crc_exp;
    logic [3:0][15:0]            crc_val;

    assign line_mask = bw4_q ? 4'hF : 4'h1;
    assign start_bit = bw4_q ? (dat_i == 4'h0) : ~dat_i[0];
    assign last_idx  = (bw4_q ? {2'b00, blk_size_q, 1'b0} : {blk_size_q, 3'b000}) - CntW'(1);
    assign last_data = (bit_cnt_q == last_idx);

    // Abort suppresses every sampling action in its cycle.
    assign smp       = sd_clk_en_i & ~abort_i;
    assign start_acc = (state_q == ST_IDLE) & start_i & ~abort_i;
    assign data_smp  = smp & (state_q == ST_DATA);
    assign crc_smp   = smp & (state_q == ST_CRC);
    assign end_smp   = smp & (state_q == ST_END_BIT);

    always_comb begin
        state_d = state_q;
        if (abort_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       if (start_acc) state_d = ST_WAIT_START;
                ST_WAIT_START: if (sd_clk_en_i && start_bit)
                                   state_d = (blk_size_q == '0) ? ST_CRC : ST_DATA;
                ST_DATA:       if (sd_clk_en_i && last_data) state_d = ST_CRC;
                ST_CRC:        if (sd_clk_en_i && crc_cnt_q == 4'd15) state_d = ST_END_BIT;
                ST_END_BIT:    if (sd_clk_en_i) state_d = ST_DONE;
                ST_DONE:       state_d = ST_IDLE;
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        byte_next = bw4_q ? {byte_q[3:0], dat_i} : {byte_q[6:0], dat_i[0]};
        byte_done = bw4_q ? bit_cnt_q[0] : (bit_cnt_q[2:0] == 3'd7);
        word_next = word_q;
        word_next[{lane_q, 3'b000} +: 8] = byte_next;
        for (int i = 0; i < 4; i++) begin
            crc_exp[i] = crc_val[i][4'd15 - crc_cnt_q];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blk_size_q   <= '0;
            bw4_q        <= 1'b0;
            bit_cnt_q    <= '0;
            crc_cnt_q    <= '0;
            byte_q       <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            crc_err_q    <= 1'b0;
            end_err_q    <= 1'b0;
            data_valid_o <= 1'b0;
            data_o       <= '0;
        end else begin
            data_valid_o <= 1'b0;
            if (start_acc) begin
                blk_size_q <= block_size_i;
                bw4_q      <= bus_width_is_4_i;
                bit_cnt_q  <= '0;
                crc_cnt_q  <= '0;
                byte_q     <= '0;
                lane_q     <= '0;
                word_q     <= '0;
                crc_err_q  <= 1'b0;
                end_err_q  <= 1'b0;
            end
            if (data_smp) begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
                byte_q    <= byte_next;
                // The last sample always closes a byte, so a partial word flushes here too.
                if (byte_done && (lane_q == 2'd3 || last_data)) begin
                    data_o       <= word_next;
                    data_valid_o <= 1'b1;
                    word_q       <= '0;
                    lane_q       <= '0;
                end else if (byte_done) begin
                    word_q <= word_next;
                    lane_q <= lane_q + 2'd1;
                end
            end
            if (crc_smp) begin
                crc_cnt_q <= crc_cnt_q + 4'd1;
                if (|((crc_exp ^ dat_i) & line_mask)) crc_err_q <= 1'b1;
            end
            if (end_smp && |(~dat_i & line_mask)) begin
                end_err_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_crc
        sd_crc16 u_crc (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clear_i  (start_acc),
            .enable_i (data_smp),
            .bit_i    (dat_i[g]),
            .crc_o    (crc_val[g])
        );
    end

    assign done_o        = (state_q == ST_DONE);
    assign crc_err_o     = done_o & crc_err_q;
    assign end_bit_err_o = done_o & end_err_q;

endmodule

// File: tb/tb_dat_rx_deserializer.sv
// Directed bench for dat_rx_deserializer: 1/4-bit blocks, CRC and end-bit errors, abort, reset.
// Samples are spaced by idle cycles so sd_clk_en_i gating is exercised.
// Outputs are observed on the falling clock edge.
module tb_dat_rx_deserializer;

    localparam int MBS = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sd_clk_en = 1'b0;
    logic [3:0]     dat = 4'hF;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [MBS-1:0] bsize = '0;
    logic           bw4 = 1'b0;
    logic           dv, done, crc_err, end_err;
    logic [31:0]    dout;

    always #5 clk = ~clk;

    dat_rx_deserializer #(.MaxBlockBitSize(MBS)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .sd_clk_en_i      (sd_clk_en),
        .dat_i            (dat),
        .start_i          (start),
        .abort_i          (abort),
        .block_size_i     (bsize),
        .bus_width_is_4_i (bw4),
        .data_valid_o     (dv),
        .data_o           (dout),
        .done_o           (done),
        .crc_err_o        (crc_err),
        .end_bit_err_o    (end_err)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] words[$];
    int          done_cnt = 0;
    logic        last_crc = 1'b0;
    logic        last_end = 1'b0;
    int          flag_leak = 0;
    logic [7:0]  blk [0:511];

    always @(negedge clk) begin
        if (dv) words.push_back(dout);
        if (done) begin
            done_cnt++;
            last_crc = crc_err;
            last_end = end_err;
        end else if (crc_err || end_err) begin
            flag_leak++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        if (i < words.size()) return words[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    task automatic clear_obs();
        words.delete();
        done_cnt = 0;
        last_crc = 1'b0;
        last_end = 1'b0;
    endtask

    task automatic sample(input logic [3:0] d);
        @(negedge clk);
        dat = d;
        sd_clk_en = 1'b1;
        @(negedge clk);
        sd_clk_en = 1'b0;
        @(negedge clk);
    endtask

    // cut_at >= 0 aborts (or resets, if cut_rst) in place of that post-start-bit sample.
    task automatic run_block(input bit w4, input int n, input int bad_line, input bit end_ok,
                             input int cut_at, input bit cut_rst);
        logic [3:0]       seq[$];
        logic [3:0][15:0] crcs;
        logic [3:0]       d;
        logic [7:0]       b;
        crcs = '0;
        for (int k = 0; k < n; k++) begin
            b = blk[k];
            if (w4) begin
                for (int h = 1; h >= 0; h--) begin
                    d = (h == 1) ? b[7:4] : b[3:0];
                    for (int l = 0; l < 4; l++) crcs[l] = crc_step(crcs[l], d[l]);
                    seq.push_back(d);
                end
            end else begin
                for (int j = 7; j >= 0; j--) begin
                    crcs[0] = crc_step(crcs[0], b[j]);
                    seq.push_back({3'b111, b[j]});
                end
            end
        end
        for (int j = 15; j >= 0; j--) begin
            d = w4 ? {crcs[3][j], crcs[2][j], crcs[1][j], crcs[0][j]} : {3'b000, crcs[0][j]};
            if (j == 5 && bad_line >= 0) d[bad_line[1:0]] = ~d[bad_line[1:0]];
            seq.push_back(d);
        end
        seq.push_back(end_ok ? 4'hF : (w4 ? 4'h0 : 4'hE));

        @(negedge clk);
        bsize = n[MBS-1:0];
        bw4   = w4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bsize = ~bsize;
        bw4   = ~w4;
        sample(4'hF);
        sample(4'h0);
        for (int i = 0; i < seq.size(); i++) begin
            if (i == cut_at) begin
                if (cut_rst) begin
                    @(negedge clk);
                    #2 rst = 1'b1;
                    #1;
                    check("rst_data_o", dout, 32'h0);
                    check("rst_valid", {31'b0, dv}, 32'h0);
                    check("rst_done", {31'b0, done}, 32'h0);
                    check("rst_flags", {30'b0, crc_err, end_err}, 32'h0);
                    @(negedge clk);
                    rst = 1'b0;
                end else begin
                    @(negedge clk);
                    dat = seq[i];
                    sd_clk_en = 1'b1;
                    abort = 1'b1;
                    @(negedge clk);
                    sd_clk_en = 1'b0;
                    abort = 1'b0;
                end
                repeat (4) @(negedge clk);
                return;
            end
            sample(seq[i]);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valid", {31'b0, dv}, 32'h0);
        check("reset_data", dout, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_crc_err", {31'b0, crc_err}, 32'h0);
        check("reset_end_err", {31'b0, end_err}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1-bit, 4 bytes
        blk[0] = 8'h01; blk[1] = 8'h02; blk[2] = 8'h03; blk[3] = 8'h04;
        clear_obs();
        run_block(1'b0, 4, -1, 1'b1, -1, 1'b0);
        check("t1_nwords", words.size(), 32'd1);
        check("t1_word0", word_at(0), 32'h0403_0201);
        check("t1_done", done_cnt, 32'd1);
        check("t1_crc_err", {31'b0, last_crc}, 32'h0);
        check("t1_end_err", {31'b0, last_end}, 32'h0);

        // 4-bit, 512 random bytes
        for (int k = 0; k < 512; k++) blk[k] = 8'($urandom);
        clear_obs();
        run_block(1'b1, 512, -1, 1'b1, -1, 1'b0);
        check("t2_nwords", words.size(), 32'd128);
        for (int w = 0; w < 128; w++)
            check($sformatf("t2_word%0d", w), word_at(w),
                  {blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]});
        check("t2_done", done_cnt, 32'd1);
        check("t2_flags", {30'b0, last_crc, last_end}, 32'h0);

        // 4-bit, 8 bytes, line-2 CRC bit flipped
        for (int k = 0; k < 8; k++) blk[k] = 8'h10 * k[7:0] + 8'h3;
        clear_obs();
        run_block(1'b1, 8, 2, 1'b1, -1, 1'b0);
        check("t3_nwords", words.size(), 32'd2);
        check("t3_done", done_cnt, 32'd1);
        check("t3_crc_err", {31'b0, last_crc}, 32'h1);
        check("t3_end_err", {31'b0, last_end}, 32'h0);

        // 1-bit, 6 bytes, end bit 0
        blk[0] = 8'hA1; blk[1] = 8'hB2; blk[2] = 8'hC3; blk[3] = 8'hD4; blk[4] = 8'hE5; blk[5] = 8'hF6;
        clear_obs();
        run_block(1'b0, 6, -1, 1'b0, -1, 1'b0);
        check("t4_nwords", words.size(), 32'd2);
        check("t4_word0", word_at(0), 32'hD4C3_B2A1);
        check("t4_word1", word_at(1), 32'h0000_F6E5);
        check("t4_done", done_cnt, 32'd1);
        check("t4_end_err", {31'b0, last_end}, 32'h1);
        check("t4_crc_err", {31'b0, last_crc}, 32'h0);

        // abort mid-DATA, then a clean block
        blk[0] = 8'hDE; blk[1] = 8'hAD; blk[2] = 8'hBE; blk[3] = 8'hEF;
        clear_obs();
        run_block(1'b0, 4, -1, 1'b1, 10, 1'b0);
        repeat (20) sample(4'hF);
        check("t5_abort_done", done_cnt, 32'd0);
        check("t5_abort_words", words.size(), 32'd0);
        blk[0] = 8'h11; blk[1] = 8'h22; blk[2] = 8'h33; blk[3] = 8'h44;
        run_block(1'b0, 4, -1, 1'b1, -1, 1'b0);
        check("t5_done", done_cnt, 32'd1);
        check("t5_word0", word_at(0), 32'h4433_2211);
        check("t5_flags", {30'b0, last_crc, last_end}, 32'h0);

        // reset pulsed mid-CRC (16 data samples, then 5 CRC samples)
        blk[0] = 8'h5A; blk[1] = 8'hA5;
        clear_obs();
        run_block(1'b0, 2, -1, 1'b1, 21, 1'b0 | 1'b1);
        repeat (20) sample(4'hF);
        check("t6_no_done", done_cnt, 32'd0);
        check("t6_pre_word", word_at(0), 32'h0000_A55A);
        clear_obs();
        run_block(1'b0, 2, -1, 1'b1, -1, 1'b0);
        check("t6_done", done_cnt, 32'd1);
        check("t6_word0", word_at(0), 32'h0000_A55A);

        // zero-length block, 4-bit
        clear_obs();
        run_block(1'b1, 0, -1, 1'b1, -1, 1'b0);
        check("t7_nwords", words.size(), 32'd0);
        check("t7_done", done_cnt, 32'd1);
        check("t7_flags", {30'b0, last_crc, last_end}, 32'h0);

        check("flags_outside_done", flag_leak, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
